// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding for the countdown timer.
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that pulses tick once every DIV enabled cycles.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] pre;
  assign tick = enable && pre == LAST;
  always_ff @(posedge clock)
    if (reset || clear) pre <= '0;
    else if (enable) pre <= tick ? '0 : pre + 1'b1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with prescaled ticks, pause/resume and optional auto-reload.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         pause,
  input  logic         auto_reload,
  output logic [N-1:0] cnt,
  output logic         busy,
  output logic         done
);
  state_t state, state_n;
  logic [N-1:0] reload, cnt_n, reload_n;
  logic done_n, tick, clear, enable, rearm;
  assign busy   = state != IDLE;
  assign clear  = load || (state == IDLE && start);
  assign enable = state == RUN && !load && !pause;
  assign rearm  = auto_reload && reload != '0;
  tick_gen #(.DIV(DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .tick   (tick)
  );
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload;
    done_n   = 1'b0;
    if (load) begin
      cnt_n    = load_value;
      reload_n = load_value;
      state_n  = IDLE;
    end else if (start && state != RUN) begin
      state_n = (state == IDLE && cnt == '0) ? IDLE : RUN;
      done_n  = state == IDLE && cnt == '0;
    end else if (state == RUN) begin
      if (pause) state_n = PAUSED;
      else if (tick && cnt > N'(1)) cnt_n = cnt - 1'b1;
      else if (tick) begin
        // auto_reload only matters here, at the terminal tick
        cnt_n   = rearm ? reload : '0;
        state_n = rearm ? RUN : IDLE;
        done_n  = 1'b1;
      end
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      reload <= reload_n;
      done   <= done_n;
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer (DIV=2 and DIV=1 instances).
module tb_countdown_timer;
  logic clock = 1'b0, reset = 1'b1;
  logic load = 1'b0, start = 1'b0, pause = 1'b0, ar = 1'b0;
  logic [3:0] lv = '0, cnt;
  logic busy, done;
  logic load1 = 1'b0, start1 = 1'b0, pause1 = 1'b0, ar1 = 1'b1;
  logic [3:0] lv1 = '0, cnt1;
  logic busy1, done1;
  int checks = 0, errors = 0;
  int exp_p [14] = '{4, 3, 3, 2, 2, 2, 2, 2, 2, 2, 2, 1, 1, 0};
  always #5 clock = ~clock;
  countdown_timer #(.N(4), .DIV(2)) dut (
    .clock(clock), .reset(reset), .load(load), .load_value(lv), .start(start),
    .pause(pause), .auto_reload(ar), .cnt(cnt), .busy(busy), .done(done)
  );
  countdown_timer #(.N(4), .DIV(1)) dut1 (
    .clock(clock), .reset(reset), .load(load1), .load_value(lv1), .start(start1),
    .pause(pause1), .auto_reload(ar1), .cnt(cnt1), .busy(busy1), .done(done1)
  );
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    load = 1'b1; lv = 4'd5;
    cyc();
    load = 1'b0;
    chk("ld5_cnt", cnt, 5);
    chk("ld5_busy", busy, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_k0_cnt", cnt, 5);
    chk("run_k0_busy", busy, 1);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk($sformatf("run_k%0d_cnt", k), cnt, 5 - k / 2);
      chk($sformatf("run_k%0d_done", k), done, k == 10);
      chk($sformatf("run_k%0d_busy", k), busy, k < 10);
    end
    cyc();
    chk("run_after_done", done, 0);
    load1 = 1'b1; lv1 = 4'd3;
    cyc();
    load1 = 1'b0; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    chk("ar_k0_cnt", cnt1, 3);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk($sformatf("ar_k%0d_cnt", k), cnt1, 3 - (k % 3));
      chk($sformatf("ar_k%0d_done", k), done1, k % 3 == 0);
      chk($sformatf("ar_k%0d_busy", k), busy1, 1);
    end
    load = 1'b1; lv = 4'd4;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      pause = k >= 5 && k <= 9;
      start = k == 10;
      cyc();
      chk($sformatf("pz_k%0d_cnt", k), cnt, exp_p[k-1]);
      chk($sformatf("pz_k%0d_done", k), done, k == 14);
      chk($sformatf("pz_k%0d_busy", k), busy, k < 14);
    end
    pause = 1'b0; start = 1'b0;
    load = 1'b1; lv = 4'd0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_cnt", cnt, 0);
    cyc();
    chk("z_done_clr", done, 0);
    chk("z_busy2", busy, 0);
    load = 1'b1; start = 1'b1; lv = 4'd7;
    cyc();
    load = 1'b0; start = 1'b0;
    chk("ls_cnt", cnt, 7);
    chk("ls_busy", busy, 0);
    chk("ls_done", done, 0);
    cyc();
    chk("ls_busy2", busy, 0);
    chk("ls_cnt2", cnt, 7);
    load = 1'b1; lv = 4'd5;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) cyc();
    chk("mr_cnt3", cnt, 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mr_cnt", cnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("mr_nodone_%0d", k), done, 0);
    end
    reset = 1'b1; load = 1'b1; lv = 4'd9;
    cyc();
    reset = 1'b0; load = 1'b0;
    chk("rl_cnt", cnt, 0);
    chk("rl_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
